oscope_trigger_capture: RTL

Trigger and capture engine for the oscilloscope IP. It sits directly downstream of the AXI4-Lite control/status registers (slv_reg0..3), which feed it arm/mode/level/pretrigger values and read back its status. It consumes the ADC sample stream, detects a level-crossing trigger, and writes a pretrigger-plus-posttrigger record into a circular sample BRAM.

---
 rtl/oscope_pkg.sv | 24 ++
 rtl/oscope_trig_detect.sv | 37 +++
 rtl/oscope_trigger_capture.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/oscope_pkg.sv
// Shared definitions for the oscilloscope trigger/capture engine: FSM state encoding
// and the bit layout of the ctrl/status registers in the AXI4-Lite slave.
package oscope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int CTRL_ARM       = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int CTRL_EDGE_FALL = 2;
    localparam int CTRL_AUTO      = 3;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_TRIGGERED  = 1;
    localparam int STAT_FORCED     = 2;
    localparam int STAT_DONE       = 3;
    localparam int STAT_START_ADDR = 16;

endpackage

// File: rtl/oscope_trig_detect.sv
// Level-crossing detector: keeps the previous accepted sample and flags a rising or
// falling crossing of trig_level on the current sample (combinational hit).
module oscope_trig_detect #(
    parameter int SAMPLE_W = 12
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                clear,
    input  logic                sample_en,
    input  logic                edge_fall,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                hit
);

    logic [SAMPLE_W-1:0] prev;
    logic                prev_valid;
    logic                rise_cross;
    logic                fall_cross;

    always_ff @(posedge aclk) begin
        if (areset) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev_valid <= 1'b0;
        end else if (sample_en) begin
            prev       <= s_data;
            prev_valid <= 1'b1;
        end
    end

    assign rise_cross = (prev < trig_level) && (trig_level <= s_data);
    assign fall_cross = (prev >= trig_level) && (trig_level > s_data);
    assign hit        = sample_en && prev_valid && (edge_fall ? fall_cross : rise_cross);

endmodule

// File: rtl/oscope_trigger_capture.sv
// Trigger/capture FSM: prefills pre_cnt samples, waits for a level crossing (or an
// auto-timeout), then completes a DEPTH-sample circular record in the sample BRAM.
//
// state | meaning
// IDLE  | no capture, no writes
// PRE   | writing pretrigger prefill, no trigger detection yet
// WAIT  | writing circularly, looking for a crossing or timeout
// POST  | writing the remaining posttrigger samples
// DONE  | record complete, status held until next arm
module oscope_trigger_capture
    import oscope_pkg::*;
#(
    parameter int SAMPLE_W  = 12,
    parameter int ADDR_W    = 10,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 edge_fall,
    input  logic                 auto_mode,
    input  logic [SAMPLE_W-1:0]  trig_level,
    input  logic [ADDR_W-1:0]    pre_cnt,
    input  logic [TIMEOUT_W-1:0] timeout,
    input  logic                 s_valid,
    input  logic [SAMPLE_W-1:0]  s_data,
    output logic                 buf_we,
    output logic [ADDR_W-1:0]    buf_addr,
    output logic [SAMPLE_W-1:0]  buf_din,
    output logic                 busy,
    output logic                 triggered,
    output logic                 forced,
    output logic                 done,
    output logic [ADDR_W-1:0]    start_addr
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_PRE  = ST_PRE;
    localparam logic [2:0] S_WAIT = ST_WAIT;
    localparam logic [2:0] S_POST = ST_POST;
    localparam logic [2:0] S_DONE = ST_DONE;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [2:0]           state;
    logic [ADDR_W-1:0]    wp;
    logic [ADDR_W-1:0]    pre_eff;
    logic [ADDR_W-1:0]    pre_left;
    logic [ADDR_W-1:0]    post_left;
    logic [TIMEOUT_W-1:0] to_left;
    logic                 auto_en;
    logic                 write_en;
    logic                 track_en;
    logic                 hit;
    logic                 timed_out;

    assign busy      = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign write_en  = busy && s_valid && !arm && !abort;
    assign track_en  = write_en && ((state == S_PRE) || (state == S_WAIT));
    assign timed_out = auto_en && (to_left == TIMEOUT_W'(1));

    oscope_trig_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_trig_detect (
        .aclk       (aclk),
        .areset     (areset),
        .clear      (arm),
        .sample_en  (track_en),
        .edge_fall  (edge_fall),
        .trig_level (trig_level),
        .s_data     (s_data),
        .hit        (hit)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= S_IDLE;
            wp         <= '0;
            pre_eff    <= '0;
            pre_left   <= '0;
            post_left  <= '0;
            to_left    <= '0;
            auto_en    <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_din    <= '0;
            triggered  <= 1'b0;
            forced     <= 1'b0;
            done       <= 1'b0;
            start_addr <= '0;
        end else begin
            buf_we <= 1'b0;

            if (write_en) begin
                buf_we   <= 1'b1;
                buf_addr <= wp;
                buf_din  <= s_data;
                wp       <= wp + ADDR_W'(1);
            end

            if (arm) begin
                // pre_cnt is ADDR_W wide, so it can never exceed DEPTH-1 and needs no clamp
                wp        <= '0;
                pre_eff   <= pre_cnt;
                pre_left  <= pre_cnt;
                to_left   <= timeout;
                auto_en   <= auto_mode && (timeout != '0);
                triggered <= 1'b0;
                forced    <= 1'b0;
                done      <= 1'b0;
                state     <= (pre_cnt == '0) ? S_WAIT : S_PRE;
            end else if (abort && busy) begin
                triggered <= 1'b0;
                forced    <= 1'b0;
                state     <= S_IDLE;
            end else begin
                case (state)
                    S_PRE: begin
                        if (s_valid) begin
                            if (pre_left == ADDR_W'(1)) state <= S_WAIT;
                            pre_left <= pre_left - ADDR_W'(1);
                        end
                    end
                    S_WAIT: begin
                        if (s_valid) begin
                            if (hit || timed_out) begin
                                triggered  <= 1'b1;
                                forced     <= !hit;
                                start_addr <= wp - pre_eff;
                                post_left  <= ADDR_MAX - pre_eff;
                                // with a full prefill the trigger sample itself closes the record
                                state      <= (pre_eff == ADDR_MAX) ? S_DONE : S_POST;
                            end else if (auto_en) begin
                                to_left <= to_left - TIMEOUT_W'(1);
                            end
                        end
                    end
                    S_POST: begin
                        if (s_valid) begin
                            if (post_left == ADDR_W'(1)) state <= S_DONE;
                            post_left <= post_left - ADDR_W'(1);
                        end
                    end
                    S_DONE: begin
                        done <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
